dcache_req_trace_encoder: RTL and testbench
===========================================

Name: dcache_req_trace_encoder

Overview:
- Consumes the D-cache request probe stream tapped from the tile core: valid/ready, addr, tag, cmd, size, signed, phys, no_alloc, data.
- Turns each fired load, store or AMO request into a compact trace record, with optional address compression, a timestamp and overflow marking.
- Buffers records in a small FIFO and presents them on a valid/ready stream to the trace funnel.
- Non-intrusive: never backpressures the core; records are dropped when the buffer is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- COMPRESS, 1, enables short-address records; 0 makes every record a full-address record.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  trace enable; when low, nothing is captured.
- req_valid  in  1  tapped request valid.
- req_ready  in  1  tapped request ready.
- req_addr  in  32  request address.
- req_tag  in  6  request tag.
- req_cmd  in  5  memory command code.
- req_size  in  2  log2 of the access size in bytes.
- req_signed  in  1  sign-extend flag; passed through.
- req_phys  in  1  physical-address flag; passed through.
- req_no_alloc  in  1  no-allocate hint; ignored.
- req_data  in  32  store/AMO data.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- out_kind  out  2  0 load, 1 store, 2 AMO; 3 is never produced.
- out_full  out  1  1 = out_addr holds a full address; 0 = low 8 bits only, upper bits zero.
- out_addr  out  32  address field.
- out_tag  out  6  tag.
- out_size  out  2  size.
- out_signed  out  1  signed flag.
- out_phys  out  1  phys flag.
- out_data  out  32  req_data for store/AMO; 0 for load.
- out_ovf  out  1  one or more records were dropped before this one.
- out_time  out  16  cycle counter value at capture.
- drop_count  out  16  saturating count of dropped records.

Behaviour:
- Reset (synchronous): FIFO empty, out_valid=0, all out_* data outputs 0, drop_count=0, time counter 0, last-address-valid=0, pending-overflow=0.
- Time counter: free-running 16-bit; increments every cycle after reset and wraps 0xFFFF->0x0000.
- fire = enable & req_valid & req_ready.
- Command classification:
  - load: cmd 0x00 or 0x06.
  - store: cmd 0x01, 0x07 or 0x11.
  - AMO: cmd 0x04 or 0x08-0x0F.
  - Any other cmd (prefetch, flush, clean, sfence, ...): no record, no drop, last-address state unchanged.
- Capture stage: a fire with a traced cmd forms a record using the current time-counter value.
- Address compression:
  - out_full=0 only when COMPRESS=1, last-address-valid=1, req_addr[31:8]==last_addr[31:8], and pending-overflow=0.
  - Otherwise out_full=1 with the full address.
  - last_addr is updated only on records actually written to the FIFO. A dropped record does not update it.
- FIFO push condition: not full, or full with a pop in the same cycle (out_valid & out_ready).
- Empty FIFO with simultaneous push and no pop: the record appears on out_* the next cycle. Latency is fire at cycle N -> out_valid at N+1. No combinational path from req_* to out_*.
- Drop (full, no pop):
  - drop_count increments, saturating at 0xFFFF.
  - pending-overflow is set and last-address-valid is cleared.
- Overflow marking: the next pushed record carries out_ovf=1 and out_full=1. pending-overflow clears on that push.
- Output handshake:
  - out_* fields stay stable while out_valid=1 and out_ready=0.
  - Pop on out_valid & out_ready; the next entry is presented the following cycle.
  - Pointers wrap modulo DEPTH.
- enable low: no capture, last-address-valid cleared. The FIFO keeps draining, and drop_count and pending-overflow are retained.
- Reset mid-operation: queued records are discarded with no partial output. The cycle after reset deasserts, out_valid=0.

Test Plan:
- Reset, enable=1, single load fire at addr 0x8000_1234, tag 5, size 2 -> next cycle out_valid=1, kind 0, full=1, addr 0x8000_1234, data 0, ovf=0.
- Store to 0x8000_1240 with data 0xDEADBEEF right after the above -> kind 1, full=0, addr 0x40, data 0xDEADBEEF. Repeat with COMPRESS=0 -> full=1, addr 0x8000_1240.
- out_ready=0, 6 consecutive store fires, DEPTH=4 -> 4 records held, drop_count=2. Then out_ready=1 and one more fire -> 4 records drain in order, and the 5th record has ovf=1 and full=1 even though its upper address bits match.
- cmd 0x02 (prefetch), 0x05 and 0x14 fires -> no record, drop_count unchanged. cmd 0x0A fire -> kind 2 with data passed through.
- Full FIFO with out_ready=1 and a fire in the same cycle -> record accepted, no drop; occupancy unchanged.
- Time-counter wrap: fire at time 0xFFFF and again 1 cycle later -> out_time 0xFFFF then 0x0000. Assert reset with 3 queued records -> out_valid=0 after reset, drop_count=0.

Source files
------------

// File: rtl/dcache_req_trace_encoder.sv
// dcache_req_trace_encoder
//
// Watches the D-cache request probe stream of the tile core and turns every
// fired load, store or AMO request into a compact trace record. Records are
// buffered in a small FIFO and offered to the trace funnel on a valid/ready
// stream. The core is never backpressured: when the FIFO is full and nothing
// pops in the same cycle, the record is dropped and counted.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   enable              trace enable; low = nothing captured
//   req_*               tapped request probe (valid/ready, addr, tag, cmd,
//                       size, signed, phys, no_alloc, data)
//   out_valid/out_ready record stream towards the trace funnel
//   out_kind            0 load, 1 store, 2 AMO
//   out_full            1 = out_addr is the full address, 0 = low byte only
//   out_addr, out_tag, out_size, out_signed, out_phys, out_data
//   out_ovf             one or more records were dropped before this one
//   out_time            16-bit cycle counter value at capture
//   drop_count          saturating count of dropped records
//
// Handshake: a record transfers on a cycle where out_valid and out_ready are
// both high; while out_valid is high and out_ready low, every out_* field is
// held stable. The request side is a passive tap: fire = enable & req_valid &
// req_ready, and this block never drives req_ready.
module dcache_req_trace_encoder #(
  parameter int DEPTH    = 4,
  parameter bit COMPRESS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_valid,
  input  logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [5:0]  req_tag,
  input  logic [4:0]  req_cmd,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic        req_phys,
  input  logic        req_no_alloc,
  input  logic [31:0] req_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic        out_full,
  output logic [31:0] out_addr,
  output logic [5:0]  out_tag,
  output logic [1:0]  out_size,
  output logic        out_signed,
  output logic        out_phys,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic [15:0] out_time,
  output logic [15:0] drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic        full;
    logic [31:0] addr;
    logic [5:0]  tag;
    logic [1:0]  size;
    logic        sgn;
    logic        phys;
    logic [31:0] data;
    logic        ovf;
    logic [15:0] tstamp;
  } rec_t;

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   time_q;
  logic [15:0]   drop_count_q;
  logic [31:0]   last_addr_q;
  logic          last_valid_q;
  logic          pend_ovf_q;

  // The no-allocate hint carries no information the trace needs.
  logic unused_no_alloc;
  assign unused_no_alloc = req_no_alloc;

  logic is_load, is_store, is_amo, traced;
  logic fire, cap, fifo_full, pop, push, drop, short_ok;
  rec_t rec_d;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_amo   = 1'b0;
    case (req_cmd)
      5'h00, 5'h06:        is_load  = 1'b1;
      5'h01, 5'h07, 5'h11: is_store = 1'b1;
      5'h04, 5'h08, 5'h09, 5'h0A, 5'h0B,
      5'h0C, 5'h0D, 5'h0E, 5'h0F: is_amo = 1'b1;
      default: ;
    endcase
  end

  assign traced    = is_load | is_store | is_amo;
  assign fire      = enable & req_valid & req_ready;
  assign cap       = fire & traced;
  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push      = cap & (~fifo_full | pop);
  assign drop      = cap & fifo_full & ~pop;

  // After a drop the consumer cannot trust its reconstructed upper address
  // bits, so the record following a gap is always a full-address record.
  assign short_ok = COMPRESS && last_valid_q && !pend_ovf_q &&
                    (req_addr[31:8] == last_addr_q[31:8]);

  always_comb begin
    rec_d        = '0;
    rec_d.kind   = is_amo ? 2'd2 : (is_store ? 2'd1 : 2'd0);
    rec_d.full   = ~short_ok;
    rec_d.addr   = short_ok ? {24'h0, req_addr[7:0]} : req_addr;
    rec_d.tag    = req_tag;
    rec_d.size   = req_size;
    rec_d.sgn    = req_signed;
    rec_d.phys   = req_phys;
    rec_d.data   = is_load ? 32'h0 : req_data;
    rec_d.ovf    = pend_ovf_q;
    rec_d.tstamp = time_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      time_q       <= '0;
      drop_count_q <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
    end else begin
      time_q <= time_q + 16'd1;

      if (push) begin
        mem_q[wr_ptr_q] <= rec_d;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);

      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);

      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;

      // Only records that reach the FIFO become the compression reference.
      if (!enable) begin
        last_valid_q <= 1'b0;
      end else if (push) begin
        last_valid_q <= 1'b1;
        last_addr_q  <= req_addr;
      end else if (drop) begin
        last_valid_q <= 1'b0;
      end

      if (push)      pend_ovf_q <= 1'b0;
      else if (drop) pend_ovf_q <= 1'b1;
    end
  end

  rec_t head;
  assign head       = mem_q[rd_ptr_q];
  assign out_kind   = head.kind;
  assign out_full   = head.full;
  assign out_addr   = head.addr;
  assign out_tag    = head.tag;
  assign out_size   = head.size;
  assign out_signed = head.sgn;
  assign out_phys   = head.phys;
  assign out_data   = head.data;
  assign out_ovf    = head.ovf;
  assign out_time   = head.tstamp;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dcache_req_trace_encoder.sv
module tb_dcache_req_trace_encoder;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0, req_valid = 1'b0, req_ready = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [5:0]  req_tag = '0;
  logic [4:0]  req_cmd = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0, req_phys = 1'b0, req_no_alloc = 1'b0;
  logic        out_ready = 1'b0;

  logic        out_valid, out_full, out_signed, out_phys, out_ovf;
  logic [1:0]  out_kind, out_size;
  logic [31:0] out_addr, out_data;
  logic [5:0]  out_tag;
  logic [15:0] out_time, drop_count;

  logic        nc_valid, nc_full, nc_signed, nc_phys, nc_ovf;
  logic [1:0]  nc_kind, nc_size;
  logic [31:0] nc_addr, nc_data;
  logic [5:0]  nc_tag;
  logic [15:0] nc_time, nc_drop_count;

  dcache_req_trace_encoder #(.DEPTH(4), .COMPRESS(1'b1)) dut (
    .clock(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_tag(req_tag), .req_cmd(req_cmd), .req_size(req_size),
    .req_signed(req_signed), .req_phys(req_phys), .req_no_alloc(req_no_alloc),
    .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_full(out_full), .out_addr(out_addr), .out_tag(out_tag),
    .out_size(out_size), .out_signed(out_signed), .out_phys(out_phys),
    .out_data(out_data), .out_ovf(out_ovf), .out_time(out_time),
    .drop_count(drop_count)
  );

  dcache_req_trace_encoder #(.DEPTH(4), .COMPRESS(1'b0)) dut_nc (
    .clock(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_tag(req_tag), .req_cmd(req_cmd), .req_size(req_size),
    .req_signed(req_signed), .req_phys(req_phys), .req_no_alloc(req_no_alloc),
    .req_data(req_data),
    .out_valid(nc_valid), .out_ready(out_ready), .out_kind(nc_kind),
    .out_full(nc_full), .out_addr(nc_addr), .out_tag(nc_tag),
    .out_size(nc_size), .out_signed(nc_signed), .out_phys(nc_phys),
    .out_data(nc_data), .out_ovf(nc_ovf), .out_time(nc_time),
    .drop_count(nc_drop_count)
  );

  // Bench-side cycle count, used as the expected timestamp.
  logic [15:0] tb_cyc = '0;
  always @(posedge clk) tb_cyc <= reset ? 16'h0 : tb_cyc + 16'd1;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- scoreboard
  logic [93:0] exp_q[$];
  logic [32:0] nc_q[$];

  function automatic logic [93:0] pack(input logic [1:0] kind, input logic full,
      input logic [31:0] addr, input logic [5:0] tag, input logic [1:0] size,
      input logic sgn, input logic phys, input logic [31:0] data, input logic ovf,
      input logic [15:0] tm);
    return {kind, full, addr, tag, size, sgn, phys, data, ovf, tm};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [93:0] got, exp;
      got = pack(out_kind, out_full, out_addr, out_tag, out_size, out_signed,
                 out_phys, out_data, out_ovf, out_time);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rec_unexpected: got %h required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rec: got kind=%0d full=%0d addr=%h tag=%0d size=%0d s=%0d p=%0d data=%h ovf=%0d time=%h required %h",
                   out_kind, out_full, out_addr, out_tag, out_size, out_signed,
                   out_phys, out_data, out_ovf, out_time, exp);
        end
      end
    end
    if (!reset && nc_valid && out_ready) begin
      logic [32:0] e;
      n_cmp++;
      if (nc_q.size() == 0) begin
        n_fail++;
        $display("FAIL nc_unexpected: got addr=%h required none", nc_addr);
      end else begin
        e = nc_q.pop_front();
        if ({nc_full, nc_addr} !== e) begin
          n_fail++;
          $display("FAIL nc_rec: got full=%0d addr=%h required full=%0d addr=%h",
                   nc_full, nc_addr, e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Called at posedge+1; the request is captured on the following edge.
  task automatic fire(input logic [4:0] cmd, input logic [31:0] addr, input logic [5:0] tag,
                      input logic [1:0] size, input logic sgn, input logic phys,
                      input logic [31:0] data);
    req_cmd = cmd; req_addr = addr; req_tag = tag; req_size = size;
    req_signed = sgn; req_phys = phys; req_data = data;
    req_no_alloc = 1'($urandom_range(0, 1));
    req_valid = 1'b1; req_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_rec(input logic [1:0] kind, input logic full, input logic [31:0] addr,
                            input logic [31:0] raw_addr, input logic [5:0] tag,
                            input logic [1:0] size, input logic sgn, input logic phys,
                            input logic [31:0] data, input logic ovf, input logic [15:0] tm);
    exp_q.push_back(pack(kind, full, addr, tag, size, sgn, phys, data, ovf, tm));
    nc_q.push_back({1'b1, raw_addr});
  endtask

  task automatic wait_drain(input string name);
    int budget = 30;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [4:0]  cmd;
    logic [31:0] addr;
    logic [5:0]  tag;
    logic [1:0]  size;
    logic        sgn;
    logic        phys;
    logic [31:0] data;
    logic        rec;
    logic [1:0]  kind;
    logic        full;
    logic [31:0] eaddr;
    logic [31:0] edata;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] cmd, input logic [31:0] addr,
      input logic [5:0] tag, input logic [1:0] size, input logic sgn, input logic phys,
      input logic [31:0] data, input logic rec, input logic [1:0] kind,
      input logic full, input logic [31:0] eaddr, input logic [31:0] edata);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.tag = tag; v.size = size; v.sgn = sgn; v.phys = phys;
    v.data = data; v.rec = rec; v.kind = kind; v.full = full; v.eaddr = eaddr; v.edata = edata;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5'h00, 32'h8000_1234, 6'd5,  2'd2, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 2'd0, 1'b1, 32'h8000_1234, 32'h0);
    vecs[1]  = mk(5'h01, 32'h8000_1240, 6'd6,  2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 2'd1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
    vecs[2]  = mk(5'h07, 32'h8000_12FF, 6'd7,  2'd0, 1'b1, 1'b0, 32'h0000_00A5, 1'b1, 2'd1, 1'b0, 32'h0000_00FF, 32'h0000_00A5);
    vecs[3]  = mk(5'h11, 32'h8000_1300, 6'd8,  2'd1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 2'd1, 1'b1, 32'h8000_1300, 32'h1234_5678);
    vecs[4]  = mk(5'h06, 32'h8000_1310, 6'd9,  2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'h0);
    vecs[5]  = mk(5'h02, 32'h9000_0000, 6'd10, 2'd2, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    vecs[6]  = mk(5'h05, 32'h9000_0000, 6'd11, 2'd2, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    vecs[7]  = mk(5'h14, 32'h9000_0000, 6'd12, 2'd2, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    vecs[8]  = mk(5'h0A, 32'h8000_1320, 6'd13, 2'd2, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_0001);
    vecs[9]  = mk(5'h04, 32'h0000_0010, 6'd14, 2'd2, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 2'd2, 1'b1, 32'h0000_0010, 32'h0000_0001);
    vecs[10] = mk(5'h0F, 32'h0000_0055, 6'd15, 2'd3, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 2'd2, 1'b0, 32'h0000_0055, 32'h0000_0002);
    vecs[11] = mk(5'h08, 32'h0000_0100, 6'd63, 2'd2, 1'b0, 1'b0, 32'h0000_0003, 1'b1, 2'd2, 1'b1, 32'h0000_0100, 32'h0000_0003);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_time", 32'(out_time), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Table: back-to-back fires with a free-flowing consumer
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rec)
        expect_rec(vecs[i].kind, vecs[i].full, vecs[i].eaddr, vecs[i].addr, vecs[i].tag,
                   vecs[i].size, vecs[i].sgn, vecs[i].phys, vecs[i].edata, 1'b0, tb_cyc);
      fire(vecs[i].cmd, vecs[i].addr, vecs[i].tag, vecs[i].size, vecs[i].sgn,
           vecs[i].phys, vecs[i].data);
    end
    wait_drain("table_drain");
    check("table_drop_count", 32'(drop_count), 32'd0);

    // valid without ready is not a fire
    req_cmd = 5'h01; req_addr = 32'h0000_0104; req_valid = 1'b1; req_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // enable low: no capture, and the compression reference is forgotten
    enable = 1'b0;
    fire(5'h00, 32'h0000_0120, 6'd1, 2'd2, 1'b0, 1'b0, 32'h0);
    enable = 1'b1;
    expect_rec(2'd1, 1'b1, 32'h0000_0124, 32'h0000_0124, 6'd2, 2'd2, 1'b0, 1'b0,
               32'h0BAD_F00D, 1'b0, tb_cyc);
    fire(5'h01, 32'h0000_0124, 6'd2, 2'd2, 1'b0, 1'b0, 32'h0BAD_F00D);
    wait_drain("enable_drain");

    // Overflow: stalled consumer, six stores into a four-entry buffer
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        expect_rec(2'd1, (i == 0), (i == 0) ? 32'h8000_2000 : 32'(4 * i),
                   32'h8000_2000 + 32'(4 * i), 6'(20 + i), 2'd2, 1'b0, 1'b0,
                   32'(i), 1'b0, tb_cyc);
      fire(5'h01, 32'h8000_2000 + 32'(4 * i), 6'(20 + i), 2'd2, 1'b0, 1'b0, 32'(i));
    end
    @(posedge clk); #1;
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    check("ovf_hold_addr", out_addr, 32'h8000_2000);

    // Full buffer, pop and push in the same cycle: accepted, not dropped
    out_ready = 1'b1;
    expect_rec(2'd1, 1'b1, 32'h8000_2018, 32'h8000_2018, 6'd30, 2'd2, 1'b0, 1'b0,
               32'h0000_0006, 1'b1, tb_cyc);
    fire(5'h01, 32'h8000_2018, 6'd30, 2'd2, 1'b0, 1'b0, 32'h0000_0006);
    // Occupancy is still four, so a further fire while stalled must drop
    out_ready = 1'b0;
    check("swap_drop_count", 32'(drop_count), 32'd2);
    fire(5'h01, 32'h8000_201C, 6'd31, 2'd2, 1'b0, 1'b0, 32'h0000_0007);
    check("swap_full_drop", 32'(drop_count), 32'd3);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    expect_rec(2'd1, 1'b1, 32'h8000_2020, 32'h8000_2020, 6'd32, 2'd2, 1'b0, 1'b0,
               32'h0000_0008, 1'b1, tb_cyc);
    fire(5'h01, 32'h8000_2020, 6'd32, 2'd2, 1'b0, 1'b0, 32'h0000_0008);
    expect_rec(2'd1, 1'b0, 32'h0000_0024, 32'h8000_2024, 6'd33, 2'd2, 1'b0, 1'b0,
               32'h0000_0009, 1'b0, tb_cyc);
    fire(5'h01, 32'h8000_2024, 6'd33, 2'd2, 1'b0, 1'b0, 32'h0000_0009);
    wait_drain("post_ovf_drain");

    // Time-counter wrap
    while (tb_cyc != 16'hFFFF) begin
      @(posedge clk); #1;
    end
    expect_rec(2'd1, 1'b0, 32'h0000_0028, 32'h8000_2028, 6'd40, 2'd2, 1'b0, 1'b0,
               32'h0000_00AA, 1'b0, 16'hFFFF);
    fire(5'h01, 32'h8000_2028, 6'd40, 2'd2, 1'b0, 1'b0, 32'h0000_00AA);
    expect_rec(2'd1, 1'b0, 32'h0000_002C, 32'h8000_202C, 6'd41, 2'd2, 1'b0, 1'b0,
               32'h0000_00BB, 1'b0, 16'h0000);
    fire(5'h01, 32'h8000_202C, 6'd41, 2'd2, 1'b0, 1'b0, 32'h0000_00BB);
    wait_drain("wrap_drain");

    // Reset with three queued records
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      fire(5'h01, 32'h8000_3000 + 32'(4 * i), 6'd50, 2'd2, 1'b0, 1'b0, 32'(i));
    check("queued_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_drop_count", 32'(drop_count), 32'd0);
    check("post_rst_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_still_empty", 32'(out_valid), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("nc_q_empty", 32'(nc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
